addsub_pipe: RTL and testbench

//  Parametrised, pipelined add/subtract unit; successor to the 32-bit combinational adder/subtractor.

---
 rtl/addsub_pipe.sv | 139 +++++++++++++
 tb/tb_addsub_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: the WIDTH-bit carry chain is resolved CHUNK bits per
// stage, with valid/ready handshaking, signed overflow handling and Z/C/N/V flags.
module addsub_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CHUNK  = 8,
    parameter bit          SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);

    // WIDTH must be a multiple of CHUNK with at least two chunks.
    localparam int unsigned NSTG = WIDTH / CHUNK;
    localparam int unsigned NM   = NSTG - 1;
    localparam int unsigned MSB  = WIDTH - 1;

    logic             advance;

    logic [NM-1:0]    vld;
    logic [WIDTH-1:0] a_q   [NM];
    logic [WIDTH-1:0] bx_q  [NM];
    logic [1:0]       mode_q[NM];
    logic [WIDTH-1:0] sum_q [NM];
    logic             cy_q  [NM];

    logic [NSTG-1:0]  src_v;
    logic [WIDTH-1:0] src_a   [NSTG];
    logic [WIDTH-1:0] src_bx  [NSTG];
    logic [1:0]       src_mode[NSTG];
    logic [WIDTH-1:0] src_sum [NSTG];
    logic             src_c   [NSTG];
    logic [CHUNK:0]   csum    [NSTG];
    logic [WIDTH-1:0] sum_nxt [NSTG];

    logic [WIDTH-1:0] res_nxt;
    logic             zero_nxt;
    logic             car_nxt;
    logic             neg_nxt;
    logic             ovf_nxt;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Stage k consumes the register of stage k-1 (stage 0 reads the ports) and adds chunk k.
    always_comb begin
        src_v[0]    = in_valid;
        src_a[0]    = a;
        src_bx[0]   = b ^ {WIDTH{aluc[0]}};
        src_mode[0] = aluc;
        src_sum[0]  = '0;
        src_c[0]    = aluc[0];
        for (int unsigned k = 1; k < NSTG; k++) begin
            src_v[k]    = vld[k-1];
            src_a[k]    = a_q[k-1];
            src_bx[k]   = bx_q[k-1];
            src_mode[k] = mode_q[k-1];
            src_sum[k]  = sum_q[k-1];
            src_c[k]    = cy_q[k-1];
        end
        for (int unsigned k = 0; k < NSTG; k++) begin
            csum[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                    + {1'b0, src_bx[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, src_c[k]};
            sum_nxt[k] = src_sum[k];
            sum_nxt[k][k*CHUNK +: CHUNK] = csum[k][CHUNK-1:0];
        end
    end

    always_comb begin
        res_nxt = sum_nxt[NM];
        car_nxt = 1'b0;
        neg_nxt = 1'b0;
        ovf_nxt = 1'b0;
        if (!src_mode[NM][1]) begin
            car_nxt = csum[NM][CHUNK] ^ src_mode[NM][0];
        end else begin
            ovf_nxt = (src_a[NM][MSB] == src_bx[NM][MSB]) && (sum_nxt[NM][MSB] != src_a[NM][MSB]);
            if (ovf_nxt) begin
                if (SAT_EN)
                    res_nxt = src_a[NM][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                else
                    res_nxt = '0;
            end
            neg_nxt = res_nxt[MSB];
        end
        zero_nxt = (res_nxt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            for (int unsigned k = 0; k < NM; k++) begin
                a_q[k]    <= '0;
                bx_q[k]   <= '0;
                mode_q[k] <= '0;
                sum_q[k]  <= '0;
                cy_q[k]   <= 1'b0;
            end
        end else if (advance) begin
            for (int unsigned k = 0; k < NM; k++) begin
                vld[k] <= src_v[k];
                if (src_v[k]) begin
                    a_q[k]    <= src_a[k];
                    bx_q[k]   <= src_bx[k];
                    mode_q[k] <= src_mode[k];
                    sum_q[k]  <= sum_nxt[k];
                    cy_q[k]   <= csum[k][CHUNK];
                end
            end
            out_valid <= src_v[NM];
            if (src_v[NM]) begin
                result   <= res_nxt;
                zero     <= zero_nxt;
                carry    <= car_nxt;
                negative <= neg_nxt;
                overflow <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Randomised and directed bench for addsub_pipe: three instances (32/8, 32/8 saturating,
// 16/4) run in lockstep and are scored against an integer-arithmetic reference model.
module tb_addsub_pipe;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  m;
    } beat_t;

    localparam int WID [3] = '{32, 32, 16};
    localparam bit SATV[3] = '{1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  aluc;
    logic [31:0] a32;
    logic [31:0] b32;

    logic [31:0] r  [3];
    logic [3:0]  f  [3];
    logic        ov [3];
    logic        ir [3];

    logic [31:0] r0, r1;
    logic [15:0] r2;
    logic        z0, c0, n0, o0, z1, c1, n1, o1, z2, c2, n2, o2;
    logic        ov0, ov1, ov2, ir0, ir1, ir2;

    beat_t       sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_no  = 0;
    bit          last_acc = 1'b0;
    bit          held     = 1'b0;
    logic [31:0] hold_r[3];
    logic [3:0]  hold_f[3];

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(32), .CHUNK(8), .SAT_EN(1'b0)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .a(a32), .b(b32),
        .aluc(aluc), .out_valid(ov0), .out_ready(out_ready), .result(r0),
        .zero(z0), .carry(c0), .negative(n0), .overflow(o0));

    addsub_pipe #(.WIDTH(32), .CHUNK(8), .SAT_EN(1'b1)) u_w32s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a32), .b(b32),
        .aluc(aluc), .out_valid(ov1), .out_ready(out_ready), .result(r1),
        .zero(z1), .carry(c1), .negative(n1), .overflow(o1));

    addsub_pipe #(.WIDTH(16), .CHUNK(4), .SAT_EN(1'b0)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .a(a32[15:0]), .b(b32[15:0]),
        .aluc(aluc), .out_valid(ov2), .out_ready(out_ready), .result(r2),
        .zero(z2), .carry(c2), .negative(n2), .overflow(o2));

    assign r[0] = r0;
    assign r[1] = r1;
    assign r[2] = {16'h0, r2};
    assign f[0] = {z0, c0, n0, o0};
    assign f[1] = {z1, c1, n1, o1};
    assign f[2] = {z2, c2, n2, o2};
    assign ov[0] = ov0;
    assign ov[1] = ov1;
    assign ov[2] = ov2;
    assign ir[0] = ir0;
    assign ir[1] = ir1;
    assign ir[2] = ir2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    // Flags packed as {zero, carry, negative, overflow}.
    function automatic void model(input int w, input bit sat, input logic [31:0] ai,
                                  input logic [31:0] bi, input logic [1:0] m,
                                  output logic [31:0] res, output logic [3:0] flg);
        longint md, half, ua, ub, sa, sb, s;
        bit z, c, n, o;
        md   = longint'(1) << w;
        half = md / 2;
        ua   = longint'({32'h0, ai}) & (md - 1);
        ub   = longint'({32'h0, bi}) & (md - 1);
        c = 1'b0; n = 1'b0; o = 1'b0;
        if (!m[1]) begin
            if (!m[0]) begin
                s = ua + ub;
                c = (s >= md);
            end else begin
                s = ua - ub;
                c = (ua < ub);
            end
            s = s & (md - 1);
        end else begin
            sa = (ua >= half) ? ua - md : ua;
            sb = (ub >= half) ? ub - md : ub;
            s  = m[0] ? sa - sb : sa + sb;
            if (s >= half || s < -half) begin
                o = 1'b1;
                s = sat ? ((s > 0) ? half - 1 : half) : 0;
            end else begin
                s = s & (md - 1);
            end
            n = s[w-1];
        end
        z   = (s == 0);
        res = s[31:0];
        flg = {z, c, n, o};
    endfunction

    task automatic cyc(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [1:0] im, input logic ordy);
        beat_t       bt;
        logic [31:0] er;
        logic [3:0]  ef;
        @(negedge clk);
        in_valid  = iv;
        a32       = ia;
        b32       = ib;
        aluc      = im;
        out_ready = ordy;
        #1;
        cyc_no++;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("in_ready[%0d]", i), ir[i], !ov[i] || ordy);
            if (i > 0) check($sformatf("ov_sync[%0d]", i), ov[i], ov[0]);
        end
        if (held) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("stall_valid[%0d]", i), ov[i], 1'b1);
                check($sformatf("stall_result[%0d]", i), r[i], hold_r[i]);
                check($sformatf("stall_flags[%0d]", i), f[i], hold_f[i]);
            end
            held = 1'b0;
        end
        if (ov[0] && !ordy) begin
            held   = 1'b1;
            hold_r = r;
            hold_f = f;
        end
        if (ov[0] && ordy) begin
            if (sbq.size() == 0) begin
                check("spurious_out", ov[0], 1'b0);
            end else begin
                bt = sbq.pop_front();
                for (int i = 0; i < 3; i++) begin
                    model(WID[i], SATV[i], bt.a, bt.b, bt.m, er, ef);
                    check($sformatf("result[%0d] a=%h b=%h m=%b", i, bt.a, bt.b, bt.m), r[i], er);
                    check($sformatf("flags_zcnv[%0d] a=%h b=%h m=%b", i, bt.a, bt.b, bt.m), f[i], ef);
                end
            end
        end
        last_acc = iv && ir[0];
        if (last_acc) sbq.push_back('{a: ia, b: ib, m: im});
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && sbq.size() != 0; t++) cyc(1'b0, '0, '0, 2'b00, 1'b1);
        check("drain_empty", sbq.size(), 0);
    endtask

    task automatic one(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] im);
        int c_acc;
        bit seen;
        seen = 1'b0;
        cyc(1'b1, ia, ib, im, 1'b1);
        check("one_accept", last_acc, 1'b1);
        c_acc = cyc_no;
        for (int t = 0; t < 20 && sbq.size() != 0; t++) begin
            cyc(1'b0, '0, '0, 2'b00, 1'b1);
            if (!seen && ov[0]) begin
                seen = 1'b1;
                check("latency", cyc_no - c_acc, 4);
            end
        end
        check("one_done", sbq.size(), 0);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h8000_0000;
            5:       return 32'h0000_7FFF;
            6:       return 32'h0000_8000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int          sent;
        int          j;
        logic [31:0] sa_op[8];
        logic [31:0] sb_op[8];
        logic [1:0]  sm_op[8];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; aluc = 2'b00; a32 = '0; b32 = '0;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_out_valid[%0d]", i), ov[i], 1'b0);
            check($sformatf("reset_result[%0d]", i), r[i], 32'h0);
            check($sformatf("reset_flags[%0d]", i), f[i], 4'h0);
            check($sformatf("reset_in_ready[%0d]", i), ir[i], 1'b1);
        end
        @(negedge clk);
        rst = 1'b0;

        one(32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
        one(32'h7FFF_FFFF, 32'h0000_0001, 2'b10);
        one(32'h0000_0005, 32'h0000_0007, 2'b01);
        one(32'h0000_0005, 32'h0000_0007, 2'b11);
        one(32'h8000_0000, 32'h0000_0001, 2'b11);
        one(32'h0000_0000, 32'h8000_0000, 2'b11);
        one(32'h8000_0000, 32'h8000_0000, 2'b10);
        one(32'h0000_0003, 32'h0000_0003, 2'b01);

        // Back-pressure: out_ready low on stream cycles 5-7; each beat held until accepted.
        for (int i = 0; i < 8; i++) begin
            sa_op[i] = rnd_op();
            sb_op[i] = rnd_op();
            sm_op[i] = 2'($urandom_range(0, 3));
        end
        sent = 0;
        j = 1;
        while (sent < 8 && j < 40) begin
            cyc(1'b1, sa_op[sent], sb_op[sent], sm_op[sent], !(j >= 5 && j <= 7));
            if (last_acc) sent++;
            j++;
        end
        check("stream_sent", sent, 8);
        drain();

        for (int t = 0; t < 600; t++)
            cyc($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 2'($urandom_range(0, 3)),
                $urandom_range(0, 9) < 7);
        drain();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) cyc(1'b1, rnd_op(), rnd_op(), 2'($urandom_range(0, 3)), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midrst_out_valid[%0d]", i), ov[i], 1'b0);
            check($sformatf("midrst_result[%0d]", i), r[i], 32'h0);
        end
        sbq.delete();
        held = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 12; t++) begin
            cyc(1'b0, '0, '0, 2'b00, 1'b1);
            check("post_rst_idle", ov[0], 1'b0);
        end
        one(32'h1234_5678, 32'h0FED_CBA9, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
